// File: rtl/rgb_burst_packer.sv
// rgb_burst_packer: frames each 24-bit pixel burst from the FIFO read-out
// stage into 32-bit packet words (header, LSB-first packed payload, trailer)
// and buffers them in a first-word-fall-through FIFO feeding a valid/ready
// link interface. The pixel input has no backpressure, so words that find the
// FIFO full are dropped and flagged on the sticky overflow_err.
// Build option: define RGB_PACK_CHECKSUM_EN to append an XOR-of-payload
// checksum word after the trailer (the checksum then carries tx_last).
module rgb_burst_packer #(
  parameter int          FIFO_DEPTH = 128,
  parameter logic [15:0] HDR_TAG    = 16'hA5A5,
  parameter logic [7:0]  TRL_TAG    = 8'h5A,
  parameter int          END_HOLD   = 4
) (
  input  logic        clk_200MHz,
  input  logic        reset,
  input  logic [23:0] RGB_data,
  input  logic        valid_RGB_data,
  input  logic        flag_RGB_data,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        overflow_err,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(END_HOLD + 1);

`ifdef RGB_PACK_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, BURST, FLUSH, TRL, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, BURST, FLUSH, TRL} state_t;
`endif

  state_t          state;
  logic            flag_p0;
  logic            rearm;
  logic [HW-1:0]   hold_cnt;
  logic [1:0]      grp;
  logic [15:0]     pix_cnt;
  logic [7:0]      burst_id;
  logic [23:0]     pix_p0;
  logic [31:0]     word_p0;
  logic            vld_p0;

  logic            start;
  logic            pix_acc;
  logic            push_en;
  logic [31:0]     push_word;
  logic            push_last;

  logic [32:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            pop;
  logic            wr;
  logic [32:0]     head;

  // Within a group of four pixels the bit stream is LSB-first, so a word is
  // always completed by the current pixel plus leftover bits of the previous
  // one; only that previous pixel ever needs to be held.
  function automatic logic [31:0] pack_word(input logic [1:0] g,
                                            input logic [23:0] prev,
                                            input logic [23:0] px);
    case (g)
      2'd1:    return {px[7:0], prev};
      2'd2:    return {px[15:0], prev[23:8]};
      2'd3:    return {px, prev[23:16]};
      default: return 32'h0;
    endcase
  endfunction

  // Leftover bits of an incomplete group, zero-padded towards the MSB.
  function automatic logic [31:0] tail_word(input logic [1:0] g,
                                            input logic [23:0] prev);
    case (g)
      2'd1:    return {8'h00, prev};
      2'd2:    return {16'h0000, prev[23:8]};
      2'd3:    return {24'h000000, prev[23:16]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pix_acc = (state == BURST) && valid_RGB_data;
  // A flag already high on the first IDLE cycle after a packet rose during
  // the flush/trailer phase and counts as a fresh edge.
  assign start   = (state == IDLE) && flag_RGB_data && (!flag_p0 || rearm);

  // Packet framing FSM with burst counters and the idle drop counter
  always_ff @(posedge clk_200MHz) begin
    flag_p0 <= flag_RGB_data;
    if (reset) begin
      state    <= IDLE;
      rearm    <= 1'b0;
      hold_cnt <= '0;
      grp      <= 2'd0;
      pix_cnt  <= 16'd0;
      burst_id <= 8'd0;
      vld_p0   <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      vld_p0 <= pix_acc && (grp != 2'd0);
      rearm  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_RGB_data) drop_cnt <= sat_inc8(drop_cnt);
          if (start) begin
            state    <= BURST;
            hold_cnt <= '0;
          end
        end
        BURST: begin
          if (valid_RGB_data) begin
            grp     <= grp + 2'd1;
            pix_cnt <= pix_cnt + 16'd1;
          end
          if (flag_RGB_data) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HW'(END_HOLD - 1)) begin
            hold_cnt <= '0;
            state    <= FLUSH;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        // wait for a word still staged from the final pixel before the tail
        FLUSH: if (!vld_p0) state <= TRL;
        TRL: begin
          burst_id <= burst_id + 8'd1;
          pix_cnt  <= 16'd0;
          grp      <= 2'd0;
`ifdef RGB_PACK_CHECKSUM_EN
          state    <= CHK;
`else
          state    <= IDLE;
          rearm    <= 1'b1;
`endif
        end
`ifdef RGB_PACK_CHECKSUM_EN
        CHK: begin
          state <= IDLE;
          rearm <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel stage: keep the previous pixel and stage each completed word
  always_ff @(posedge clk_200MHz) begin
    if (pix_acc) begin
      pix_p0  <= RGB_data;
      word_p0 <= pack_word(grp, pix_p0, RGB_data);
    end
  end

`ifdef RGB_PACK_CHECKSUM_EN
  logic [31:0] chk;
  logic        payload_push;
  assign payload_push = vld_p0 || ((state == FLUSH) && (grp != 2'd0));

  // Running XOR of every payload word, restarted by each header
  always_ff @(posedge clk_200MHz) begin
    if (start) chk <= 32'h0;
    else if (payload_push) chk <= chk ^ push_word;
  end
`endif

  // Word source for the FIFO; staged payload words never collide with the
  // FSM-generated header/tail/trailer words
  always_comb begin
    push_en   = 1'b0;
    push_word = 32'h0;
    push_last = 1'b0;
    if (vld_p0) begin
      push_en   = 1'b1;
      push_word = word_p0;
    end else begin
      case (state)
        IDLE: if (start) begin
          push_en   = 1'b1;
          push_word = {HDR_TAG, burst_id, 8'h00};
        end
        FLUSH: if (grp != 2'd0) begin
          push_en   = 1'b1;
          push_word = tail_word(grp, pix_p0);
        end
        TRL: begin
          push_en   = 1'b1;
          push_word = {TRL_TAG, burst_id, pix_cnt};
`ifdef RGB_PACK_CHECKSUM_EN
          push_last = 1'b0;
`else
          push_last = 1'b1;
`endif
        end
`ifdef RGB_PACK_CHECKSUM_EN
        CHK: begin
          push_en   = 1'b1;
          push_word = chk;
          push_last = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign full     = (count == (AW + 1)'(FIFO_DEPTH));
  assign tx_valid = (count != '0);
  assign pop      = tx_valid && tx_ready;
  assign wr       = push_en && (!full || pop);
  assign head     = mem[rd_ptr];
  assign tx_data  = tx_valid ? head[31:0] : 32'h0;
  assign tx_last  = tx_valid && head[32];

  // FIFO storage
  always_ff @(posedge clk_200MHz) begin
    if (wr) mem[wr_ptr] <= {push_last, push_word};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk_200MHz) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_en && full && !pop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_burst_packer.sv
// Testbench for rgb_burst_packer: table-driven bursts plus hand-written
// corner sequences, checked against a bit-stream packet model.
module tb_rgb_burst_packer;

  localparam int END_HOLD = 4;
`ifdef RGB_PACK_CHECKSUM_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic        clk_200MHz;
  logic        reset;
  logic [23:0] RGB_data;
  logic        valid_RGB_data;
  logic        flag_RGB_data;
  logic        tx_ready, tx_ready_s;
  logic [31:0] tx_data, tx_data_s;
  logic        tx_valid, tx_valid_s, tx_last, tx_last_s;
  logic        overflow_err, overflow_err_s;
  logic [7:0]  drop_cnt, drop_cnt_s;

  rgb_burst_packer u_dut (
    .clk_200MHz(clk_200MHz), .reset(reset), .RGB_data(RGB_data),
    .valid_RGB_data(valid_RGB_data), .flag_RGB_data(flag_RGB_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .overflow_err(overflow_err), .drop_cnt(drop_cnt)
  );

  rgb_burst_packer #(.FIFO_DEPTH(16)) u_small (
    .clk_200MHz(clk_200MHz), .reset(reset), .RGB_data(RGB_data),
    .valid_RGB_data(valid_RGB_data), .flag_RGB_data(flag_RGB_data),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_last(tx_last_s),
    .tx_ready(tx_ready_s), .overflow_err(overflow_err_s), .drop_cnt(drop_cnt_s)
  );

  initial clk_200MHz = 1'b0;
  always #5 clk_200MHz = ~clk_200MHz;

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 1;
  int bid = 0;

  logic [32:0] got_q[$];
  logic [32:0] got_s[$];
  logic [32:0] exp_q[$];
  logic [23:0] px_q[$];

  logic [32:0] held;
  logic        stalled = 1'b0;

  typedef struct {
    int npix;
    int gap_max;
    int rmode;
    int exp_payload;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_200MHz);
    #1;
  endtask

  // Collect transferred words; verify the head holds still while stalled
  always @(negedge clk_200MHz) begin
    if (!reset && tx_valid && tx_ready) got_q.push_back({tx_last, tx_data});
    if (!reset && tx_valid_s && tx_ready_s) got_s.push_back({tx_last_s, tx_data_s});
    if (stalled && !reset) check("stall_hold", {31'd0, tx_valid, tx_last, tx_data}, {31'd0, 1'b1, held});
    stalled <= tx_valid && !tx_ready && !reset;
    held    <= {tx_last, tx_data};
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk_200MHz);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Expected packet from the pixel list: bit i of the payload stream is bit
  // (i mod 24) of pixel (i / 24).
  task automatic model_packet();
    int n, nw, idx;
    logic [31:0] w, x;
    logic [23:0] p;
    n  = px_q.size();
    nw = (24 * n + 31) / 32;
    x  = 32'h0;
    exp_q.push_back({1'b0, 16'hA5A5, 8'(bid), 8'h00});
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int b = 0; b < 32; b++) begin
        idx = 32 * k + b;
        if (idx < 24 * n) begin
          p    = px_q[idx / 24];
          w[b] = p[idx % 24];
        end
      end
      x ^= w;
      exp_q.push_back({1'b0, w});
    end
    exp_q.push_back({(CHK_EN == 0), 8'h5A, 8'(bid), 16'(n)});
    if (CHK_EN != 0) exp_q.push_back({1'b1, x});
    bid = (bid + 1) % 256;
  endtask

  task automatic drive_burst(input int gap_max);
    flag_RGB_data  = 1'b1;
    valid_RGB_data = 1'b0;
    repeat (6) step();
    foreach (px_q[j]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        valid_RGB_data = 1'b0;
        RGB_data       = 24'($urandom);
        step();
      end
      valid_RGB_data = 1'b1;
      RGB_data       = px_q[j];
      step();
    end
    valid_RGB_data = 1'b0;
    flag_RGB_data  = 1'b0;
    repeat (END_HOLD) step();
  endtask

  task automatic wait_stream();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 5000) begin
      step();
      t++;
    end
    repeat (20) step();
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_w%0d", name, k), got_q[k], exp_q[k]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [32:0] getw(input int k);
    if (k < got_q.size()) return got_q[k];
    return 'x;
  endfunction

  task automatic fill_ramp(input int n);
    px_q.delete();
    for (int i = 1; i <= n; i++) px_q.push_back(24'(i));
  endtask

  task automatic fill_rand(input int n);
    px_q.delete();
    for (int i = 0; i < n; i++) px_q.push_back(24'($urandom));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, base, t;
    tbl = '{'{1, 0, 1, 1}, '{2, 1, 2, 2}, '{3, 2, 2, 3}, '{4, 0, 2, 3},
            '{7, 3, 1, 6}, '{8, 1, 2, 6}, '{64, 1, 2, 48}, '{123, 2, 2, 93}};
    reset = 1'b1; flag_RGB_data = 1'b0; valid_RGB_data = 1'b0; RGB_data = 24'h0;
    tx_ready_s = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // Ramp burst of 123 pixels
    fill_ramp(123);
    model_packet();
    drive_burst(0);
    wait_stream();
    check("s1_hdr", getw(0), 33'h0_A5A50000);
    check("s1_w1", getw(1), 33'h0_02000001);
    check("s1_trl", getw(94), {(CHK_EN == 0), 32'h5A00007B});
    check("s1_overflow", overflow_err, 0);
    compare_stream("s1");

    // Two back-to-back 5-pixel bursts (ids 1 and 2)
    fill_rand(5);
    model_packet();
    drive_burst(1);
    fill_rand(5);
    model_packet();
    drive_burst(1);
    wait_stream();
    check("s2_pad", getw(4) & 33'h0_FF000000, 33'h0);
    check("s2_trl1", getw(5), {(CHK_EN == 0), 32'h5A010005});
    check("s2_hdr2", getw(6 + CHK_EN), 33'h0_A5A50200);
    compare_stream("s2");

    // Table: burst length vs payload word count, random data/gaps/ready
    for (int v = 0; v < 8; v++) begin
      ready_mode = tbl[v].rmode;
      fill_rand(tbl[v].npix);
      model_packet();
      drive_burst(tbl[v].gap_max);
      wait_stream();
      check($sformatf("tbl%0d_words", v), got_q.size(), tbl[v].exp_payload + 2 + CHK_EN);
      compare_stream($sformatf("tbl%0d", v));
    end
    ready_mode = 1;

    // Long consumer stall in the middle of a burst
    fill_ramp(123);
    model_packet();
    fork
      drive_burst(0);
      begin
        repeat (30) step();
        ready_mode = 0;
        repeat (300) step();
        ready_mode = 1;
      end
    join
    wait_stream();
    check("s3_overflow", overflow_err, 0);
    compare_stream("s3");

    // Overflow on the 16-deep instance
    tx_ready_s = 1'b0;
    got_s.delete();
    fill_ramp(123);
    base = exp_q.size();
    model_packet();
    drive_burst(0);
    repeat (20) step();
    check("s4_overflow", overflow_err_s, 1);
    check("s4_none_out", got_s.size(), 0);
    tx_ready_s = 1'b1;
    repeat (40) step();
    check("s4_count", got_s.size(), 16);
    for (int k = 0; k < 16 && k < got_s.size(); k++)
      check($sformatf("s4_w%0d", k), got_s[k], exp_q[base + k]);
    check("s4_sticky", overflow_err_s, 1);
    wait_stream();
    compare_stream("s4_main");

    // Short flag dip does not end the burst; pixel in the dip is kept
    fill_rand(21);
    model_packet();
    flag_RGB_data = 1'b1; valid_RGB_data = 1'b0;
    repeat (6) step();
    for (int j = 0; j < 10; j++) begin
      valid_RGB_data = 1'b1; RGB_data = px_q[j]; step();
    end
    flag_RGB_data = 1'b0; RGB_data = px_q[10]; step();
    valid_RGB_data = 1'b0; RGB_data = 24'($urandom); step();
    flag_RGB_data = 1'b1;
    for (int j = 11; j < 21; j++) begin
      valid_RGB_data = 1'b1; RGB_data = px_q[j]; step();
    end
    valid_RGB_data = 1'b0; flag_RGB_data = 1'b0;
    repeat (END_HOLD) step();
    wait_stream();
    compare_stream("s5");

    // Pixels while idle are counted, saturating at 255
    d0 = drop_cnt;
    valid_RGB_data = 1'b1;
    repeat (3) step();
    valid_RGB_data = 1'b0;
    step();
    check("s5_drop3", drop_cnt, (d0 + 3 > 255) ? 255 : d0 + 3);
    valid_RGB_data = 1'b1;
    repeat (300) step();
    valid_RGB_data = 1'b0;
    step();
    check("s5_drop_sat", drop_cnt, 255);
    check("s5_drop_sat_s", drop_cnt_s, 255);
    repeat (5) step();
    compare_stream("s5_idle");

    // Reset in the middle of a burst
    fill_ramp(40);
    flag_RGB_data = 1'b1; valid_RGB_data = 1'b0;
    repeat (6) step();
    foreach (px_q[j]) begin
      valid_RGB_data = 1'b1; RGB_data = px_q[j]; step();
    end
    reset = 1'b1; flag_RGB_data = 1'b0; valid_RGB_data = 1'b0;
    step();
    check("s6_tx_valid", tx_valid, 0);
    check("s6_drop_cnt", drop_cnt, 0);
    check("s6_overflow_s", overflow_err_s, 0);
    reset = 1'b0;
    step();
    got_q.delete(); exp_q.delete(); got_s.delete();
    bid = 0;
    t = 0;
    repeat (5) step();
    fill_ramp(123);
    model_packet();
    drive_burst(0);
    wait_stream();
    check("s6_hdr", getw(0), 33'h0_A5A50000);
    check("s6_trl", getw(94), {(CHK_EN == 0), 32'h5A00007B});
    compare_stream("s6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
